// File: rtl/dp_pkg.sv
// dp_pkg: shared state encoding and width helpers for the dot-product datapath.
package dp_pkg;
    typedef enum logic {S_IDLE, S_ACC} dp_state_t;
    localparam int DP_IW = 19;
    localparam int DP_KMAX = 16;
    function automatic int dp_acc_width(input int iw, input int kmax);
        return iw + $clog2(kmax);
    endfunction
endpackage

// File: rtl/dp_out_reg.sv
// dp_out_reg: one-entry valid/ready holding register; reloads in the same cycle it is drained.
module dp_out_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] d,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] q,
    output logic         in_ready
);
    assign in_ready = ~out_valid | out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            q <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            q <= d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/dot_product_accum.sv
// dot_product_accum: sums a stream of per-chunk partial products into one dot product per vector,
// counting chunks and flagging vectors longer than KMAX.
module dot_product_accum
    import dp_pkg::*;
#(
    parameter int IW = DP_IW,
    parameter int KMAX = DP_KMAX,
    localparam int CW = $clog2(KMAX) + 1,
    localparam int AW = dp_acc_width(IW, KMAX)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_data,
    output logic [CW-1:0] out_count,
    output logic          out_ovf
);
    dp_state_t state;
    logic [AW-1:0] acc, sum;
    logic [CW-1:0] cnt, cnt_nx;
    logic ovf_r, ovf_nx, in_fire;
    assign in_fire = in_valid & in_ready;
    assign sum = (state == S_IDLE ? '0 : acc) + AW'(in_data);
    assign cnt_nx = cnt == CW'(KMAX) ? cnt : cnt + 1'b1;
    assign ovf_nx = ovf_r | (cnt == CW'(KMAX));
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            acc <= '0;
            cnt <= '0;
            ovf_r <= 1'b0;
        end else if (in_fire) begin
            state <= in_last ? S_IDLE : S_ACC;
            acc <= in_last ? '0 : sum;
            cnt <= in_last ? '0 : cnt_nx;
            ovf_r <= in_last ? 1'b0 : ovf_nx;
        end
    end
    dp_out_reg #(.W(AW + CW + 1)) u_out (
        .clk(clk),
        .rst(rst),
        .load(in_fire & in_last),
        .d({sum, cnt_nx, ovf_nx}),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .q({out_data, out_count, out_ovf}),
        .in_ready(in_ready)
    );
endmodule

// File: tb/tb_dot_product_accum.sv
// tb_dot_product_accum: directed and random stimulus against a scoreboard of expected dot products.
module tb_dot_product_accum;
    localparam int IW = 19;
    localparam int KMAX = 16;
    localparam int CW = $clog2(KMAX) + 1;
    localparam int AW = IW + $clog2(KMAX);

    typedef struct packed {
        logic [AW-1:0] d;
        logic [CW-1:0] c;
        logic o;
    } exp_t;

    logic tb_clk = 1'b0;
    logic rst, in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
    logic [IW-1:0] in_data;
    logic [AW-1:0] out_data;
    logic [CW-1:0] out_count;

    int total = 0, bad = 0;
    exp_t q[$];
    longint m_sum = 0;
    int m_n = 0;
    bit ir_low = 0;
    bit done = 0;

    always #5 tb_clk = ~tb_clk;

    dot_product_accum dut (
        .clk(tb_clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Model: inputs are stable at negedge, so fires decided here happen at the next rising edge.
    always @(negedge tb_clk) begin
        if (rst) begin
            q.delete();
            m_sum = 0;
            m_n = 0;
        end else begin
            if (!in_ready) ir_low = 1;
            if (out_valid && out_ready) begin
                chk("sb_has_entry", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    exp_t e;
                    e = q.pop_front();
                    chk("out_data", 64'(out_data), 64'(e.d));
                    chk("out_count", 64'(out_count), 64'(e.c));
                    chk("out_ovf", 64'(out_ovf), 64'(e.o));
                end
            end
            if (in_valid && in_ready) begin
                m_sum += longint'(in_data);
                m_n++;
                if (in_last) begin
                    exp_t e;
                    e.d = AW'(m_sum % (64'd1 << AW));
                    e.c = CW'(m_n > KMAX ? KMAX : m_n);
                    e.o = m_n > KMAX;
                    q.push_back(e);
                    m_sum = 0;
                    m_n = 0;
                end
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 just after the beat was taken.
    task automatic send(input logic [IW-1:0] d, input logic l);
        int i;
        in_valid = 1'b1;
        in_data = d;
        in_last = l;
        for (i = 0; i < 200; i++) begin
            @(negedge tb_clk);
            if (in_ready) break;
        end
        if (i == 200) chk("send_timeout", 64'd1, 64'd0);
        @(posedge tb_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 200; i++) begin
            @(negedge tb_clk);
            if (q.size() == 0 && !out_valid) break;
        end
        chk("drain", 64'(q.size()), 64'd0);
        @(posedge tb_clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_last = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge tb_clk);
        #1;
        rst = 1'b0;
        @(negedge tb_clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_ovf", 64'(out_ovf), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge tb_clk);
        #1;
        // T1: reset mid-vector discards the partial sum
        repeat (3) send(19'd5, 1'b0);
        rst = 1'b1;
        @(posedge tb_clk);
        #1;
        rst = 1'b0;
        send(19'd7, 1'b1);
        drain();
        chk("t1_data", 64'(out_data), 64'd7);
        chk("t1_count", 64'(out_count), 64'd1);
        // T2: back-to-back vectors at full throughput
        ir_low = 0;
        send(19'd10, 1'b0);
        send(19'd20, 1'b0);
        send(19'd30, 1'b1);
        send(19'd4, 1'b1);
        chk("t2_in_ready_high", 64'(ir_low), 64'd0);
        drain();
        chk("t2_last_data", 64'(out_data), 64'd4);
        // T3: held result stalls the input side
        out_ready = 1'b0;
        send(19'd10, 1'b0);
        send(19'd20, 1'b0);
        send(19'd30, 1'b1);
        in_valid = 1'b1;
        in_data = 19'd1;
        in_last = 1'b0;
        repeat (5) begin
            @(negedge tb_clk);
            chk("t3_hold_valid", 64'(out_valid), 64'd1);
            chk("t3_hold_data", 64'(out_data), 64'd60);
            chk("t3_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge tb_clk);
        #1;
        out_ready = 1'b1;
        send(19'd1, 1'b0);
        send(19'd2, 1'b1);
        drain();
        chk("t3_data", 64'(out_data), 64'd3);
        chk("t3_count", 64'(out_count), 64'd2);
        // T4: KMAX chunks of the largest partial product
        for (int i = 0; i < KMAX; i++) send({IW{1'b1}}, 1'(i == KMAX - 1));
        drain();
        chk("t4_data", 64'(out_data), 64'd8388592);
        chk("t4_count", 64'(out_count), 64'd16);
        chk("t4_ovf", 64'(out_ovf), 64'd0);
        // T5: one chunk too many flags only that vector
        for (int i = 0; i <= KMAX; i++) send(19'd1, 1'(i == KMAX));
        drain();
        chk("t5_count", 64'(out_count), 64'd16);
        chk("t5_ovf", 64'(out_ovf), 64'd1);
        send(19'd3, 1'b1);
        drain();
        chk("t5_next_ovf", 64'(out_ovf), 64'd0);
        chk("t5_next_data", 64'(out_data), 64'd3);
        // T6: random gaps and backpressure against the model
        fork
            begin
                for (int v = 0; v < 1000; v++) begin
                    int n;
                    n = $urandom_range(1, KMAX);
                    for (int c = 0; c < n; c++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge tb_clk);
                            #1;
                        end
                        send(IW'($urandom), 1'(c == n - 1));
                    end
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge tb_clk);
                    #1;
                    out_ready = $urandom_range(0, 3) != 0;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
